// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op issuer: opcodes, ALU constant, FSM states,
// the queued command record and the golden ALU function.
package alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDK = 2'b10;
    localparam logic [1:0] OP_SUBK = 2'b11;
    localparam logic [7:0] ALU_K   = 8'hAA;

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_e;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] in1;
        logic [7:0] in2;
    } cmd_t;

    function automatic logic [7:0] alu_golden(input cmd_t c);
        unique case (c.sel)
            OP_ADD:  return c.in1 + c.in2;
            OP_SUB:  return c.in1 - c.in2;
            OP_ADDK: return c.in1 + ALU_K;
            default: return c.in2 - ALU_K;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the issuer: DEPTH entries of cmd_t, synchronous push/pop,
// pointers carry one extra wrap bit to tell full from empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    cmd_t        mem [DEPTH];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/alu_op_issuer.sv
// Issues queued {sel,in1,in2} commands to a registered ALU one at a time and returns
// each result on a valid/ready port. Define ALU_CHECK_EN to enable the golden-model res_err check.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_sel,
    input  logic [7:0] cmd_in1,
    input  logic [7:0] cmd_in2,
    output logic [1:0] alu_sel,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    input  logic [7:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy,
    output logic       res_err
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmd_t             alu_q, alu_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q, res_data_d;
    logic             fifo_pop, fifo_full, fifo_empty;
    cmd_t             fifo_head;
`ifdef ALU_CHECK_EN
    logic             res_err_q, res_err_d;
`endif

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && !fifo_full),
        .wdata ('{sel: cmd_sel, in1: cmd_in1, in2: cmd_in2}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_d       = alu_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        fifo_pop    = 1'b0;
`ifdef ALU_CHECK_EN
        res_err_d   = res_err_q;
`endif
        unique case (state_q)
            IDLE: if (!fifo_empty) begin
                fifo_pop = 1'b1;
                alu_d    = fifo_head;
                state_d  = DRIVE;
            end
            DRIVE: begin
                cnt_d   = CNT_W'(ALU_LAT);
                state_d = WAIT;
            end
            // Count 1 means the ALU has had ALU_LAT edges since it sampled alu_*.
            WAIT: if (cnt_q == CNT_W'(1)) begin
                res_data_d  = alu_out;
                res_valid_d = 1'b1;
                state_d     = RESP;
`ifdef ALU_CHECK_EN
                res_err_d   = (alu_out != alu_golden(alu_q));
`endif
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            RESP: if (res_ready) begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
`ifdef ALU_CHECK_EN
                res_err_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_q       <= alu_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

`ifdef ALU_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) res_err_q <= 1'b0;
        else      res_err_q <= res_err_d;
    end
    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    assign cmd_ready = !fifo_full;
    assign alu_sel   = alu_q.sel;
    assign alu_in1   = alu_q.in1;
    assign alu_in2   = alu_q.in2;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer wrapped around a one-stage registered ALU (DEPTH=4, ALU_LAT=1):
// directed table, multi-cycle corner sequences and a randomized scoreboard run.
module tb_alu_op_issuer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_sel = '0;
    logic [7:0] cmd_in1 = '0;
    logic [7:0] cmd_in2 = '0;
    logic [1:0] alu_sel;
    logic [7:0] alu_in1, alu_in2, alu_out, alu_reg;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       busy;
    logic       res_err;
    logic       force_zero = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_issuer #(.DEPTH(4), .ALU_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_in1   (cmd_in1),
        .cmd_in2   (cmd_in2),
        .alu_sel   (alu_sel),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .res_err   (res_err)
    );

    // Reference arithmetic straight from the opcode table, mod 256.
    function automatic logic [7:0] ref_alu(input logic [1:0] sel, input logic [7:0] a,
                                           input logic [7:0] b);
        int r;
        case (sel)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b);
            2'd2:    r = int'(a) + 170;
            default: r = int'(b) - 170;
        endcase
        return 8'(r & 255);
    endfunction

    // The ALU sitting behind the issuer: one register stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) alu_reg <= '0;
        else      alu_reg <= ref_alu(alu_sel, alu_in1, alu_in2);
    end
    assign alu_out = force_zero ? 8'h00 : alu_reg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic push_cmd(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
        int cyc = 0;
        while (!cmd_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!cmd_ready) check("push timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_in1   = a;
        cmd_in2   = b;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int cyc = 0;
        while (!res_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " valid"}, 32'(res_valid), 32'd1);
    endtask

    task automatic take_result(input string name, input logic [7:0] exp, input logic exp_err);
        wait_valid(name);
        check({name, " data"}, 32'(res_data), 32'(exp));
        check({name, " err"}, 32'(res_err), 32'(exp_err));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, " drop"}, 32'(res_valid), 32'd0);
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] exp_q [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{OP_ADD,  8'h10, 8'h20, 8'h30};
        vecs[1] = '{OP_SUB,  8'h05, 8'h07, 8'hFE};
        vecs[2] = '{OP_ADDK, 8'h60, 8'h33, 8'h0A};
        vecs[3] = '{OP_SUBK, 8'h99, 8'h00, 8'h56};
        vecs[4] = '{OP_ADD,  8'hFF, 8'h01, 8'h00};
        vecs[5] = '{OP_SUB,  8'h00, 8'h01, 8'hFF};
        vecs[6] = '{OP_ADDK, 8'h56, 8'hC3, 8'h00};
        vecs[7] = '{OP_SUBK, 8'h12, 8'hAA, 8'h00};

        // Reset state
        #1;
        check("rst res_valid", 32'(res_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst alu_in1", 32'(alu_in1), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Latency: push edge counts as edge 1, result is held after edge 4.
        push_cmd(OP_ADD, 8'h10, 8'h20);
        check("lat busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("lat early", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("lat on time", 32'(res_valid), 32'd1);
        take_result("lat", 8'h30, 1'b0);

        for (int i = 0; i < 8; i++) begin
            push_cmd(vecs[i].sel, vecs[i].a, vecs[i].b);
            take_result($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
        end

        // Hold a result in RESP for 10 cycles while filling the FIFO behind it.
        push_cmd(OP_ADD, 8'h33, 8'h44);
        wait_valid("hold");
        for (int i = 0; i < 4; i++) begin
            push_cmd(2'(i), 8'h20 + 8'(i), 8'h81 + 8'(i));
            exp_q.push_back(ref_alu(2'(i), 8'h20 + 8'(i), 8'h81 + 8'(i)));
        end
        check("full after 4", 32'(cmd_ready), 32'd0);
        repeat (6) @(negedge clk);
        check("hold valid", 32'(res_valid), 32'd1);
        check("hold data", 32'(res_data), 32'h77);
        check("hold alu_sel", 32'(alu_sel), 32'(OP_ADD));
        check("hold alu_in1", 32'(alu_in1), 32'h33);
        check("hold alu_in2", 32'(alu_in2), 32'h44);
        check("hold still full", 32'(cmd_ready), 32'd0);
        take_result("hold", 8'h77, 1'b0);
        push_cmd(OP_SUBK, 8'h00, 8'h0B);
        exp_q.push_back(ref_alu(OP_SUBK, 8'h00, 8'h0B));
        for (int i = 0; i < 5; i++) take_result($sformatf("order%0d", i), exp_q.pop_front(), 1'b0);

        // Asynchronous reset while the op waits on the ALU.
        push_cmd(OP_ADD, 8'h05, 8'h05);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid rst alu_sel", 32'(alu_sel), 32'd0);
        check("mid rst alu_in1", 32'(alu_in1), 32'd0);
        check("mid rst alu_in2", 32'(alu_in2), 32'd0);
        check("mid rst res_valid", 32'(res_valid), 32'd0);
        check("mid rst res_data", 32'(res_data), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid rst res_err", 32'(res_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("discarded valid", 32'(res_valid), 32'd0);
        check("discarded busy", 32'(busy), 32'd0);
        push_cmd(OP_ADD, 8'h01, 8'h01);
        take_result("post rst", 8'h02, 1'b0);

`ifdef ALU_CHECK_EN
        force_zero = 1'b1;
        push_cmd(OP_ADD, 8'h01, 8'h01);
        take_result("forced", 8'h00, 1'b1);
        check("err cleared", 32'(res_err), 32'd0);
        force_zero = 1'b0;
        push_cmd(OP_ADD, 8'h01, 8'h01);
        take_result("unforced", 8'h02, 1'b0);
`endif

        // Randomized traffic against an in-order scoreboard.
        begin
            int pushed = 0;
            int cyc    = 0;
            exp_q.delete();
            while ((pushed < 60 || exp_q.size() != 0) && cyc < 3000) begin
                cmd_valid = (pushed < 60) && ($urandom_range(0, 1) == 1);
                cmd_sel   = 2'($urandom_range(0, 3));
                cmd_in1   = 8'($urandom_range(0, 255));
                cmd_in2   = 8'($urandom_range(0, 255));
                res_ready = ($urandom_range(0, 2) != 0);
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) check("rnd unexpected result", 32'd1, 32'd0);
                    else check("rnd data", 32'(res_data), 32'(exp_q.pop_front()));
                    check("rnd err", 32'(res_err), 32'd0);
                end
                if (cmd_valid && cmd_ready) begin
                    exp_q.push_back(ref_alu(cmd_sel, cmd_in1, cmd_in2));
                    pushed++;
                end
                @(negedge clk);
                cyc++;
            end
            cmd_valid = 1'b0;
            res_ready = 1'b0;
            check("rnd drained", 32'(exp_q.size()), 32'd0);
            check("rnd all pushed", 32'(pushed), 32'd60);
            @(negedge clk);
            check("rnd idle", 32'(busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
